// File: rtl/coproc_dispatch_if.sv
// Handshake and data bundle between the arbiter/requesters, the dispatcher
// and the shared execution unit. The master modport is the dispatcher side.
interface coproc_dispatch_if #(
   parameter int WIDTH  = 4,
   parameter int DATA_W = 16,
   parameter int OP_W   = 3
);
   logic [WIDTH-1:0]        in_grant;
   logic [WIDTH-1:0]        in_cmd_valid;
   logic [WIDTH*OP_W-1:0]   in_cmd_op;
   logic [WIDTH*DATA_W-1:0] in_cmd_a;
   logic [WIDTH*DATA_W-1:0] in_cmd_b;
   logic [WIDTH-1:0]        out_cmd_ready;
   logic                    out_exe_valid;
   logic [OP_W-1:0]         out_exe_op;
   logic [DATA_W-1:0]       out_exe_a;
   logic [DATA_W-1:0]       out_exe_b;
   logic                    in_exe_ready;
   logic                    in_exe_done;
   logic [DATA_W-1:0]       in_exe_result;
   logic [WIDTH-1:0]        out_rsp_valid;
   logic [DATA_W-1:0]       out_rsp_data;
   logic                    out_busy;
   logic                    out_error;

   modport master (
      input  in_grant, in_cmd_valid, in_cmd_op, in_cmd_a, in_cmd_b,
      input  in_exe_ready, in_exe_done, in_exe_result,
      output out_cmd_ready, out_exe_valid, out_exe_op, out_exe_a, out_exe_b,
      output out_rsp_valid, out_rsp_data, out_busy, out_error
   );

   modport slave (
      output in_grant, in_cmd_valid, in_cmd_op, in_cmd_a, in_cmd_b,
      output in_exe_ready, in_exe_done, in_exe_result,
      input  out_cmd_ready, out_exe_valid, out_exe_op, out_exe_a, out_exe_b,
      input  out_rsp_valid, out_rsp_data, out_busy, out_error
   );
endinterface

// File: rtl/coproc_dispatch.sv
// Grant-driven dispatcher: captures the granted channel's command, issues it to
// the shared execution unit and returns the result (or a timeout) to its owner.
module coproc_dispatch #(
   parameter int WIDTH   = 4,
   parameter int DATA_W  = 16,
   parameter int OP_W    = 3,
   parameter int TIMEOUT = 64
) (
   input logic              in_clk,
   input logic              in_reset,
   coproc_dispatch_if.master bus
);
   localparam int IDX_W = $clog2(WIDTH);
   localparam int CNT_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t            state;
   logic [IDX_W-1:0]  ch;
   logic [CNT_W-1:0]  cnt;
   logic [WIDTH-1:0]  cmd_ready;
   logic              exe_valid;
   logic [OP_W-1:0]   exe_op;
   logic [DATA_W-1:0] exe_a;
   logic [DATA_W-1:0] exe_b;
   logic [WIDTH-1:0]  rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;
   logic              error;

   logic [IDX_W-1:0]  grant_idx;
   logic              grant_any;
   logic              grant_multi;

   // Binary index of the grant; only meaningful when the grant is one-hot
   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (bus.in_grant[i]) grant_idx = IDX_W'(i);
      end
      grant_any   = |bus.in_grant;
      grant_multi = |(bus.in_grant & (bus.in_grant - WIDTH'(1)));
   end

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         state     <= ST_IDLE;
         ch        <= '0;
         cnt       <= '0;
         cmd_ready <= '0;
         exe_valid <= 1'b0;
         exe_op    <= '0;
         exe_a     <= '0;
         exe_b     <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         busy      <= 1'b0;
         error     <= 1'b0;
      end else begin
         cmd_ready <= '0;
         case (state)
            ST_IDLE: begin
               if (grant_multi) begin
                  error <= 1'b1;
               end else if (grant_any && bus.in_cmd_valid[grant_idx]) begin
                  ch        <= grant_idx;
                  exe_op    <= bus.in_cmd_op[int'(grant_idx)*OP_W +: OP_W];
                  exe_a     <= bus.in_cmd_a[int'(grant_idx)*DATA_W +: DATA_W];
                  exe_b     <= bus.in_cmd_b[int'(grant_idx)*DATA_W +: DATA_W];
                  cmd_ready <= bus.in_grant;
                  exe_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.in_exe_ready) begin
                  exe_valid <= 1'b0;
                  cnt       <= '0;
                  state     <= ST_WAIT;
               end
            end
            // Completion takes priority over a timeout landing on the same edge
            ST_WAIT: begin
               if (bus.in_exe_done) begin
                  rsp_data  <= bus.in_exe_result;
                  rsp_valid <= WIDTH'(1) << ch;
                  state     <= ST_RESP;
               end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  rsp_data  <= '0;
                  rsp_valid <= WIDTH'(1) << ch;
                  error     <= 1'b1;
                  state     <= ST_RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
               rsp_valid <= '0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.out_cmd_ready = cmd_ready;
   assign bus.out_exe_valid = exe_valid;
   assign bus.out_exe_op    = exe_op;
   assign bus.out_exe_a     = exe_a;
   assign bus.out_exe_b     = exe_b;
   assign bus.out_rsp_valid = rsp_valid;
   assign bus.out_rsp_data  = rsp_data;
   assign bus.out_busy      = busy;
   assign bus.out_error     = error;
endmodule

// File: tb/tb_coproc_dispatch.sv
// Directed bench for coproc_dispatch: reset, basic, back-pressure, timeout,
// grant change in flight, asynchronous reset mid-transaction and illegal grant.
module tb_coproc_dispatch;
   localparam int WIDTH   = 4;
   localparam int DATA_W  = 16;
   localparam int OP_W    = 3;
   localparam int TIMEOUT = 64;

   logic in_clk;
   logic in_reset;
   int   checks;
   int   errors;

   coproc_dispatch_if #(.WIDTH(WIDTH), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

   coproc_dispatch #(
      .WIDTH(WIDTH), .DATA_W(DATA_W), .OP_W(OP_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .in_clk  (in_clk),
      .in_reset(in_reset),
      .bus     (bus)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] grant, input logic [3:0] valid,
                                input logic ready, input logic done,
                                input logic [15:0] result);
      bus.in_grant      = grant;
      bus.in_cmd_valid  = valid;
      bus.in_exe_ready  = ready;
      bus.in_exe_done   = done;
      bus.in_exe_result = result;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      in_reset = 1'b0;
      bus.in_cmd_op = '0;
      bus.in_cmd_a  = '0;
      bus.in_cmd_b  = '0;
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();
      tick();
      in_reset = 1'b1;
      tick();
      checkOutput("reset_busy",      32'(bus.out_busy),      32'd0);
      checkOutput("reset_exe_valid", 32'(bus.out_exe_valid), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.out_rsp_valid), 32'd0);
      checkOutput("reset_cmd_ready", 32'(bus.out_cmd_ready), 32'd0);
      checkOutput("reset_error",     32'(bus.out_error),     32'd0);

      // Basic transaction on channel 2
      $display("[TB] basic transaction");
      bus.in_cmd_op[2*OP_W +: OP_W]     = 3'd3;
      bus.in_cmd_a[2*DATA_W +: DATA_W]  = 16'h0012;
      bus.in_cmd_b[2*DATA_W +: DATA_W]  = 16'h0034;
      applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("basic_cmd_ready", 32'(bus.out_cmd_ready), 32'h4);
      checkOutput("basic_exe_valid", 32'(bus.out_exe_valid), 32'd1);
      checkOutput("basic_exe_op",    32'(bus.out_exe_op),    32'd3);
      checkOutput("basic_exe_a",     32'(bus.out_exe_a),     32'h0012);
      checkOutput("basic_exe_b",     32'(bus.out_exe_b),     32'h0034);
      checkOutput("basic_busy",      32'(bus.out_busy),      32'd1);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("basic_ready_pulse_end", 32'(bus.out_cmd_ready), 32'd0);
      checkOutput("basic_exe_drop",        32'(bus.out_exe_valid), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("basic_no_early_rsp", 32'(bus.out_rsp_valid), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 16'h0046);
      tick();
      checkOutput("basic_rsp_valid", 32'(bus.out_rsp_valid), 32'h4);
      checkOutput("basic_rsp_data",  32'(bus.out_rsp_data),  32'h0046);
      checkOutput("basic_busy_resp", 32'(bus.out_busy),      32'd1);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("basic_rsp_pulse_end", 32'(bus.out_rsp_valid), 32'd0);
      checkOutput("basic_idle_busy",     32'(bus.out_busy),      32'd0);
      checkOutput("basic_rsp_hold",      32'(bus.out_rsp_data),  32'h0046);

      // Back-pressure on channel 1
      $display("[TB] back-pressure");
      bus.in_cmd_op[1*OP_W +: OP_W]     = 3'd5;
      bus.in_cmd_a[1*DATA_W +: DATA_W]  = 16'hAAAA;
      bus.in_cmd_b[1*DATA_W +: DATA_W]  = 16'h5555;
      applyStimulus(4'b0010, 4'b0010, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("bp_cmd_ready", 32'(bus.out_cmd_ready), 32'h2);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("bp_exe_valid", 32'(bus.out_exe_valid), 32'd1);
         checkOutput("bp_exe_op",    32'(bus.out_exe_op),    32'd5);
         checkOutput("bp_exe_a",     32'(bus.out_exe_a),     32'hAAAA);
         checkOutput("bp_exe_b",     32'(bus.out_exe_b),     32'h5555);
      end
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("bp_exe_drop", 32'(bus.out_exe_valid), 32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 16'hBEEF);
      tick();
      checkOutput("bp_rsp_valid", 32'(bus.out_rsp_valid), 32'h2);
      checkOutput("bp_rsp_data",  32'(bus.out_rsp_data),  32'hBEEF);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("bp_idle",     32'(bus.out_busy),  32'd0);
      checkOutput("bp_no_error", 32'(bus.out_error), 32'd0);

      // Timeout on channel 0
      $display("[TB] timeout");
      bus.in_cmd_op[0 +: OP_W]    = 3'd1;
      bus.in_cmd_a[0 +: DATA_W]   = 16'h0001;
      bus.in_cmd_b[0 +: DATA_W]   = 16'h0002;
      applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 16'h0000);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         tick();
         checkOutput("to_wait_no_rsp", 32'(bus.out_rsp_valid), 32'd0);
      end
      tick();
      checkOutput("to_rsp_valid", 32'(bus.out_rsp_valid), 32'h1);
      checkOutput("to_rsp_data",  32'(bus.out_rsp_data),  32'h0000);
      checkOutput("to_error",     32'(bus.out_error),     32'd1);
      tick();
      checkOutput("to_rsp_end", 32'(bus.out_rsp_valid), 32'd0);
      checkOutput("to_idle",    32'(bus.out_busy),      32'd0);

      // Grant moves from channel 0 to channel 3 while in flight
      $display("[TB] grant change mid-flight");
      bus.in_cmd_op[0 +: OP_W]          = 3'd2;
      bus.in_cmd_a[0 +: DATA_W]         = 16'h0010;
      bus.in_cmd_b[0 +: DATA_W]         = 16'h0020;
      bus.in_cmd_op[3*OP_W +: OP_W]     = 3'd7;
      bus.in_cmd_a[3*DATA_W +: DATA_W]  = 16'h0030;
      bus.in_cmd_b[3*DATA_W +: DATA_W]  = 16'h0040;
      applyStimulus(4'b0001, 4'b1001, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("mf_cmd_ready0", 32'(bus.out_cmd_ready), 32'h1);
      checkOutput("mf_exe_a0",     32'(bus.out_exe_a),     32'h0010);
      applyStimulus(4'b1000, 4'b1001, 1'b1, 1'b0, 16'h0000);
      tick();
      checkOutput("mf_issue_ignore", 32'(bus.out_cmd_ready), 32'd0);
      applyStimulus(4'b1000, 4'b1001, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("mf_wait_ignore", 32'(bus.out_cmd_ready), 32'd0);
      applyStimulus(4'b1000, 4'b1001, 1'b0, 1'b1, 16'h1234);
      tick();
      checkOutput("mf_rsp_owner",   32'(bus.out_rsp_valid), 32'h1);
      checkOutput("mf_rsp_data",    32'(bus.out_rsp_data),  32'h1234);
      checkOutput("mf_error_stick", 32'(bus.out_error),     32'd1);
      applyStimulus(4'b1000, 4'b1001, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("mf_resp_no_capture", 32'(bus.out_cmd_ready), 32'd0);
      checkOutput("mf_idle_busy",       32'(bus.out_busy),      32'd0);
      tick();
      checkOutput("mf_cmd_ready3", 32'(bus.out_cmd_ready), 32'h8);
      checkOutput("mf_exe_op3",    32'(bus.out_exe_op),    32'd7);
      checkOutput("mf_exe_a3",     32'(bus.out_exe_a),     32'h0030);
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000);
      tick();
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();

      // Asynchronous reset while waiting for completion
      $display("[TB] reset mid-wait");
      in_reset = 1'b0;
      #1;
      checkOutput("rst_busy",      32'(bus.out_busy),      32'd0);
      checkOutput("rst_error",     32'(bus.out_error),     32'd0);
      checkOutput("rst_exe_valid", 32'(bus.out_exe_valid), 32'd0);
      checkOutput("rst_rsp_data",  32'(bus.out_rsp_data),  32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1, 16'h7777);
      tick();
      checkOutput("rst_no_rsp", 32'(bus.out_rsp_valid), 32'd0);
      in_reset = 1'b1;
      tick();
      checkOutput("rst_after_no_rsp", 32'(bus.out_rsp_valid), 32'd0);
      checkOutput("rst_after_busy",   32'(bus.out_busy),      32'd0);
      applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();

      // Illegal multi-hot grant, then a one-hot grant without a command
      $display("[TB] illegal grant");
      applyStimulus(4'b0110, 4'b0110, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("ill_error",     32'(bus.out_error),     32'd1);
      checkOutput("ill_cmd_ready", 32'(bus.out_cmd_ready), 32'd0);
      checkOutput("ill_exe_valid", 32'(bus.out_exe_valid), 32'd0);
      checkOutput("ill_busy",      32'(bus.out_busy),      32'd0);
      applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0, 16'h0000);
      tick();
      checkOutput("novalid_cmd_ready", 32'(bus.out_cmd_ready), 32'd0);
      checkOutput("novalid_busy",      32'(bus.out_busy),      32'd0);
      checkOutput("error_sticky",      32'(bus.out_error),     32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end
endmodule

// File: doc/coproc_dispatch.md
# coproc_dispatch

Grant-driven command dispatcher sitting directly downstream of the coprocessor's round-robin arbiter. It takes the arbiter's one-hot grant, captures the granted channel's command (opcode plus two operands), issues it to the single shared execution unit over a valid/ready handshake, waits for completion and returns the result to the originating channel with a one-cycle response pulse. Only one transaction is in flight at a time; the grant is sampled only when the dispatcher is idle.

## Interface
- WIDTH, 4, number of requester channels (must equal the arbiter width, ≥2)
- DATA_W, 16, operand/result width
- OP_W, 3, opcode width
- TIMEOUT, 64, max cycles waiting for in_exe_done before abort (≥2)

- in_clk  input  1  clock, all logic on rising edge
- in_reset  input  1  asynchronous, active-low reset
- in_grant  input  WIDTH  one-hot grant from arbiter
- in_cmd_valid  input  WIDTH  per-channel command present
- in_cmd_op  input  WIDTH*OP_W  per-channel opcode, channel i at [i*OP_W +: OP_W]
- in_cmd_a, in_cmd_b  input  WIDTH*DATA_W  per-channel operands, same packing
- out_cmd_ready  output  WIDTH  one-cycle accept pulse to captured channel
- out_exe_valid  output  1  command valid to execution unit
- out_exe_op / out_exe_a / out_exe_b  output  OP_W / DATA_W / DATA_W  latched command
- in_exe_ready  input  1  execution unit accepts command
- in_exe_done  input  1  execution unit result valid (single cycle)
- in_exe_result  input  DATA_W  result
- out_rsp_valid  output  WIDTH  one-cycle response pulse, one-hot on owner channel
- out_rsp_data  output  DATA_W  result (0 on timeout)
- out_busy  output  1  high in every state except IDLE
- out_error  output  1  sticky: multi-hot grant or timeout seen

## Operation
- All outputs registered; reset drives every output, state, channel index, latches and timeout counter to 0; state → IDLE.
- IDLE: grant zero → stay. Grant multi-hot → set out_error, stay, capture nothing. Grant one-hot on channel c with in_cmd_valid[c]=1 → latch c (binary, $clog2(WIDTH) bits), op/a/b of c; pulse out_cmd_ready[c]; assert out_exe_valid; → ISSUE. One-hot grant with in_cmd_valid[c]=0 → stay.
- ISSUE: hold out_exe_valid and operands stable until in_exe_ready=1; on that edge drop out_exe_valid, clear counter, → WAIT.
- WAIT: in_exe_done=1 → latch in_exe_result into out_rsp_data, pulse out_rsp_valid[c], → RESP. Counter increments each WAIT cycle; reaching TIMEOUT-1 without done → out_rsp_data=0, set out_error, pulse out_rsp_valid[c], → RESP.
- RESP: response pulse already registered; clear out_rsp_valid, → IDLE. out_rsp_data holds until next response.
- in_grant changes while not IDLE are ignored; captured transaction always completes (or times out).
- in_exe_done outside WAIT is ignored; done on the same edge as timeout → done wins, no error.
- out_error clears only on reset.
- Asynchronous reset mid-transaction abandons it: no response pulse is generated.

## Timing
- Edge k: IDLE samples valid grant → from k: out_cmd_ready[c]=1 (one cycle), out_exe_valid=1, out_busy=1.
- in_exe_ready high at edge k+1 → out_exe_valid low after k+1; minimum exe_valid width 1 cycle.
- Done sampled at edge m → out_rsp_valid[c] high for cycle m..m+1, back to IDLE at m+1, out_busy low from m+1; new capture earliest at edge m+2.
- Minimum grant-to-response latency with ready=done=1 immediately: 3 cycles; throughput one command per 4 cycles minimum.

## Test plan
- Reset: in_reset=0 mid-WAIT → all outputs 0, state IDLE, no out_rsp_valid pulse, out_error cleared.
- Basic: grant=4'b0100, valid[2]=1, op=3, a=0x0012, b=0x0034; ready immediate, done 2 cycles later with 0x0046 → out_cmd_ready=4'b0100 one cycle, exe_op/a/b match, out_rsp_valid=4'b0100 one cycle, out_rsp_data=0x0046.
- Back-pressure: in_exe_ready held low 5 cycles → out_exe_valid and operands stable all 5 cycles, drop after ready edge.
- Timeout: no in_exe_done for TIMEOUT cycles → out_rsp_valid on owner, out_rsp_data=0, out_error=1 sticky through next good transaction.
- Grant changes mid-flight: grant moves 4'b0001→4'b1000 during WAIT → response still to channel 0; channel 3 captured only after return to IDLE.
- Illegal grant 4'b0110 in IDLE → out_error=1, no out_cmd_ready, no out_exe_valid.
